// File: rtl/instr_encoder_if.sv
// Command and encoded-word bus between a program source and the instruction encoder.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side, instr_valid/instr_ready on the word side.
interface instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [4:0]  cmd_shamt;
    logic [31:0] cmd_imm;
    logic        pc_load;
    logic [31:0] pc_load_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        err;

    // Program source side: issues commands, consumes encoded words.
    modport master (
        output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
        output pc_load, pc_load_addr, instr_ready,
        input  cmd_ready, instr_valid, instr, instr_addr, err
    );

    // Encoder side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm,
        input  pc_load, pc_load_addr, instr_ready,
        output cmd_ready, instr_valid, instr, instr_addr, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder: operation descriptors in, 32-bit words with their addresses out.
// Latency: word valid one cycle after acceptance; LI's second word loads on the first word's handshake.
// Backpressure: one-word output register; cmd_ready low while it is full and not draining, in LI_LO, or during pc_load.
module instr_encoder #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          LI_SHORT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    instr_encoder_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_addr_q, instr_addr_d;
    logic [31:0] pend_q, pend_d;
    logic        instr_valid_q, instr_valid_d;
    logic        err_q, err_d;

    logic        out_free, cmd_ready, cmd_fire;
    logic [31:0] dec_word, dec_pend;
    logic        dec_drop, dec_two;
    logic [31:0] beq_diff, beq_off;
    logic        beq_ok, li_fits;
    logic [15:0] li_hi, imm16;
    logic [4:0]  rs, rt, rd, sh;

    assign rs    = bus.cmd_rs;
    assign rt    = bus.cmd_rt;
    assign rd    = bus.cmd_rd;
    assign sh    = bus.cmd_shamt;
    assign imm16 = bus.cmd_imm[15:0];

    // The output register can take a new word when empty or draining this cycle.
    assign out_free  = !instr_valid_q || bus.instr_ready;
    assign cmd_ready = !rst && (state_q == IDLE) && out_free && !bus.pc_load;
    assign cmd_fire  = bus.cmd_valid && cmd_ready;

    // Branch offset counts words from the slot after the branch itself.
    assign beq_diff = bus.cmd_imm - (pc_q + 32'd4);
    assign beq_off  = $unsigned($signed(beq_diff) >>> 2);
    assign beq_ok   = (bus.cmd_imm[1:0] == 2'b00) && ((&beq_off[31:15]) || !(|beq_off[31:15]));
    // LUI half is rounded so the sign-extended ADDI low half lands on the exact value.
    assign li_fits  = (&bus.cmd_imm[31:15]) || !(|bus.cmd_imm[31:15]);
    assign li_hi    = bus.cmd_imm[31:16] + {15'd0, bus.cmd_imm[15]};

    // Decode the current command into its first word, optional pending ADDI, or a drop.
    always_comb begin
        dec_word = 32'd0;
        dec_pend = 32'd0;
        dec_drop = 1'b0;
        dec_two  = 1'b0;
        case (bus.cmd_op)
            4'd0:  dec_word = 32'd0;
            4'd1:  dec_word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            4'd2:  dec_word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            4'd3:  dec_word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            4'd4:  dec_word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            4'd5:  dec_word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            4'd6:  dec_word = {OP_RTYPE, 5'd0, rt, rd, sh, FN_SLL};
            4'd7:  dec_word = {OP_RTYPE, 5'd0, rt, rd, sh, FN_SRL};
            4'd8:  dec_word = {OP_RTYPE, 5'd0, rt, rd, sh, FN_SRA};
            4'd9:  dec_word = {OP_ADDI, rs, rt, imm16};
            4'd10: dec_word = {OP_LUI, 5'd0, rt, imm16};
            4'd11: dec_word = {OP_LW, rs, rt, imm16};
            4'd12: dec_word = {OP_SW, rs, rt, imm16};
            4'd13: begin
                if (beq_ok) begin
                    dec_word = {OP_BEQ, rs, rt, beq_off[15:0]};
                end else begin
                    dec_drop = 1'b1;
                end
            end
            4'd14: begin
                if (LI_SHORT && li_fits) begin
                    dec_word = {OP_ADDI, 5'd0, rt, imm16};
                end else begin
                    dec_word = {OP_LUI, 5'd0, rt, li_hi};
                    dec_pend = {OP_ADDI, rt, rt, imm16};
                    dec_two  = 1'b1;
                end
            end
            default: dec_drop = 1'b1;
        endcase
    end

    // Next state: accept commands or pc_load in IDLE, release the pending ADDI in LI_LO.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        pend_d        = pend_q;
        instr_valid_d = instr_valid_q;
        err_d         = 1'b0;
        if (instr_valid_q && bus.instr_ready) begin
            instr_valid_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (bus.pc_load && out_free) begin
                    pc_d = bus.pc_load_addr;
                end else if (cmd_fire) begin
                    if (dec_drop) begin
                        err_d = 1'b1;
                    end else begin
                        instr_d       = dec_word;
                        instr_addr_d  = pc_q;
                        pc_d          = pc_q + 32'd4;
                        instr_valid_d = 1'b1;
                        if (dec_two) begin
                            state_d = LI_LO;
                            pend_d  = dec_pend;
                        end
                    end
                end
            end
            LI_LO: begin
                if (bus.instr_ready) begin
                    instr_d       = pend_q;
                    instr_addr_d  = pc_q;
                    pc_d          = pc_q + 32'd4;
                    instr_valid_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any pending LI half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_addr_q  <= 32'd0;
            pend_q        <= 32'd0;
            instr_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            pend_q        <= pend_d;
            instr_valid_q <= instr_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
    assign bus.err         = err_q;

endmodule
